// File: rtl/mem_align_unit.sv
// mem_align_unit
// Sequential load/store alignment engine between the ALU/control path and a
// word-organised data memory. It accepts one byte, half-word or word access,
// issues one or two word-aligned memory transactions with byte-lane strobes
// and lane-positioned write data, then returns extended load data.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// ACC0  | first (or only) word transaction; mem_req=1 until mem_ack
// ACC1  | second word of a split access; mem_req=1 until mem_ack
// RESP  | one-cycle resp_valid pulse
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req_*           : access request (valid/ready, we, size, unsigned, addr, wdata)
//   resp_*          : completion pulse, extended load data, error flag
//   mem_*           : registered memory transaction outputs, mem_ack/mem_rdata in
module mem_align_unit #(
  parameter int ADDR_W   = 17,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACC0, ST_ACC1, ST_RESP} state_t;

  state_t r_state, w_state_nxt;

  // latched request fields
  logic        r_we, w_we_nxt;
  logic        r_unsigned, w_unsigned_nxt;
  logic [1:0]  r_size, w_size_nxt;
  logic [1:0]  r_off, w_off_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [3:0]  r_be_hi, w_be_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;

  // registered outputs
  logic              r_req_ready, w_req_ready_nxt;
  logic              r_resp_valid, w_resp_valid_nxt;
  logic              r_resp_err, w_resp_err_nxt;
  logic [31:0]       r_resp_rdata, w_resp_rdata_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [3:0]        r_mem_be, w_mem_be_nxt;
  logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;

  // request decode
  logic [1:0]  w_req_off;
  logic [3:0]  w_req_mask;
  logic [7:0]  w_req_span;
  logic        w_req_spans;
  logic        w_req_err;
  logic        w_unused_addr;

  assign w_req_off     = req_addr[1:0];
  assign w_unused_addr = ^req_addr[31:ADDR_W];

  always_comb begin
    case (req_size)
      2'b00:   w_req_mask = 4'b0001;
      2'b01:   w_req_mask = 4'b0011;
      default: w_req_mask = 4'b1111;
    endcase
  end

  // lanes beyond bit 3 belong to the next word
  assign w_req_span  = {4'b0000, w_req_mask} << w_req_off;
  assign w_req_spans = |w_req_span[7:4];
  assign w_req_err   = (req_size == 2'b11) || (w_req_spans && !SPLIT_EN);

  // second-word write data and address
  logic [5:0]        w_hi_shamt;
  logic [31:0]       w_acc1_wdata;
  logic [ADDR_W-1:0] w_acc1_addr;

  assign w_hi_shamt   = 6'd32 - {1'b0, r_off, 3'b000};
  assign w_acc1_wdata = r_wdata >> w_hi_shamt;
  assign w_acc1_addr  = r_mem_addr + ADDR_W'(4);

  // load extraction: {hi,lo} shifted down by the byte offset; hi is zero
  // when the access completes in ACC0
  logic [31:0] w_ld_hi, w_ld_lo, w_ld_raw, w_ld_ext;
  logic [63:0] w_ld_word;

  assign w_ld_hi   = (r_state == ST_ACC1) ? mem_rdata : 32'h0;
  assign w_ld_lo   = (r_state == ST_ACC1) ? r_lo : mem_rdata;
  assign w_ld_word = {w_ld_hi, w_ld_lo};
  assign w_ld_raw  = 32'(w_ld_word >> {r_off, 3'b000});

  always_comb begin
    case (r_size)
      2'b00:   w_ld_ext = r_unsigned ? {24'h0, w_ld_raw[7:0]}
                                     : {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
      2'b01:   w_ld_ext = r_unsigned ? {16'h0, w_ld_raw[15:0]}
                                     : {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
      default: w_ld_ext = w_ld_raw;
    endcase
  end

  // next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_we_nxt         = r_we;
    w_unsigned_nxt   = r_unsigned;
    w_size_nxt       = r_size;
    w_off_nxt        = r_off;
    w_wdata_nxt      = r_wdata;
    w_be_hi_nxt      = r_be_hi;
    w_lo_nxt         = r_lo;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = 32'h0;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_be_nxt     = r_mem_be;
    w_mem_wdata_nxt  = r_mem_wdata;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_we_nxt       = req_we;
          w_unsigned_nxt = req_unsigned;
          w_size_nxt     = req_size;
          w_off_nxt      = w_req_off;
          w_wdata_nxt    = req_wdata;
          w_be_hi_nxt    = w_req_span[7:4];
          if (w_req_err) begin
            w_state_nxt      = ST_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt     = ST_ACC0;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = req_we;
            w_mem_addr_nxt  = {req_addr[ADDR_W-1:2], 2'b00};
            w_mem_be_nxt    = w_req_span[3:0];
            w_mem_wdata_nxt = req_wdata << {w_req_off, 3'b000};
          end
        end
      end
      ST_ACC0: begin
        if (mem_ack) begin
          if (r_be_hi != 4'b0000) begin
            w_state_nxt     = ST_ACC1;
            w_lo_nxt        = mem_rdata;
            w_mem_addr_nxt  = w_acc1_addr;
            w_mem_be_nxt    = r_be_hi;
            w_mem_wdata_nxt = w_acc1_wdata;
          end else begin
            w_state_nxt      = ST_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_rdata_nxt = r_we ? 32'h0 : w_ld_ext;
            w_mem_req_nxt    = 1'b0;
            w_mem_we_nxt     = 1'b0;
            w_mem_addr_nxt   = '0;
            w_mem_be_nxt     = 4'b0000;
            w_mem_wdata_nxt  = 32'h0;
          end
        end
      end
      ST_ACC1: begin
        if (mem_ack) begin
          w_state_nxt      = ST_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = r_we ? 32'h0 : w_ld_ext;
          w_mem_req_nxt    = 1'b0;
          w_mem_we_nxt     = 1'b0;
          w_mem_addr_nxt   = '0;
          w_mem_be_nxt     = 4'b0000;
          w_mem_wdata_nxt  = 32'h0;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_req_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_wdata      <= 32'h0;
      r_be_hi      <= 4'b0000;
      r_lo         <= 32'h0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= 4'b0000;
      r_mem_wdata  <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_we         <= w_we_nxt;
      r_unsigned   <= w_unsigned_nxt;
      r_size       <= w_size_nxt;
      r_off        <= w_off_nxt;
      r_wdata      <= w_wdata_nxt;
      r_be_hi      <= w_be_hi_nxt;
      r_lo         <= w_lo_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_be     <= w_mem_be_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_align_unit.sv
// Testbench for mem_align_unit: directed cases plus randomized accesses,
// checked against a byte-level reference memory model.
module tb_mem_align_unit;
  localparam int AW   = 17;
  localparam int AMSK = (1 << AW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_valid_n, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic          req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0]   resp_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;

  logic          req_ready_n, resp_valid_n, resp_err_n, mem_req_n, mem_we_n;
  logic [31:0]   resp_rdata_n, mem_wdata_n;
  logic [AW-1:0] mem_addr_n;
  logic [3:0]    mem_be_n;
  logic          mem_ack_n;
  assign mem_ack_n = mem_req_n;

  mem_align_unit #(.ADDR_W(AW), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  mem_align_unit #(.ADDR_W(AW), .SPLIT_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .req_valid(req_valid_n), .req_ready(req_ready_n),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_n),
    .resp_rdata(resp_rdata_n), .resp_err(resp_err_n), .mem_req(mem_req_n),
    .mem_we(mem_we_n), .mem_addr(mem_addr_n), .mem_be(mem_be_n),
    .mem_wdata(mem_wdata_n), .mem_ack(mem_ack_n), .mem_rdata(mem_rdata));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // memory behind the DUT (word array) and reference byte memory
  logic [31:0] dmem [int];
  logic [7:0]  refb [int];

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] dm_rd(input int w);
    return dmem.exists(w) ? dmem[w] : init_word(w);
  endfunction

  function automatic logic [7:0] ref_rd(input int b);
    logic [31:0] t;
    if (refb.exists(b)) return refb[b];
    t = init_word(b >> 2);
    return t[8*(b & 3) +: 8];
  endfunction

  task automatic poke(input int w, input logic [31:0] v);
    dmem[w] = v;
    for (int i = 0; i < 4; i++) refb[w*4 + i] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // results of the last run_req
  logic [31:0] t_addr [4];
  logic [31:0] t_wdata[4];
  logic [3:0]  t_be   [4];
  logic        t_we   [4];
  int          nacc, lat;
  logic        got;
  logic [31:0] res_rdata;
  logic        res_err;

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int wt);
    int t0, wcnt, idx, nb, a17, off, b, k, w, e_n;
    logic stable_ok, zero_ok, busy_ok, in_txn, spans, e_err;
    logic [31:0] wv, val, e_wd[2];
    logic [3:0]  e_be[2];
    int          e_addr[2];
    nacc = 0; got = 0; lat = -1; res_rdata = 32'hx; res_err = 1'bx;
    for (int i = 0; i < 4; i++) begin
      t_addr[i] = 32'hx; t_wdata[i] = 32'hx; t_be[i] = 4'hx; t_we[i] = 1'bx;
    end
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    t0 = cyc;
    chk("ready_at_accept", req_ready, 1);
    mem_ack = 1'($urandom_range(0, 1));
    stable_ok = 1; zero_ok = 1; busy_ok = 1; in_txn = 0; wcnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      req_valid = 0; mem_ack = 0;
      @(negedge clk);
      if (req_ready) busy_ok = 0;
      if (resp_valid) begin
        got = 1; res_rdata = resp_rdata; res_err = resp_err; lat = cyc - t0;
        break;
      end
      idx = (nacc < 3) ? nacc : 3;
      if (mem_req) begin
        if (!in_txn) begin
          t_addr[idx] = 32'(mem_addr); t_be[idx] = mem_be;
          t_wdata[idx] = mem_wdata; t_we[idx] = mem_we;
          in_txn = 1; wcnt = 0;
        end else if (32'(mem_addr) !== t_addr[idx] || mem_be !== t_be[idx] ||
                     mem_wdata !== t_wdata[idx] || mem_we !== t_we[idx]) begin
          stable_ok = 0;
        end
        if (wcnt == wt) begin
          mem_ack = 1;
          w = int'(mem_addr) >> 2;
          if (mem_we) begin
            wv = dm_rd(w);
            for (int i = 0; i < 4; i++) if (mem_be[i]) wv[8*i +: 8] = mem_wdata[8*i +: 8];
            dmem[w] = wv;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = dm_rd(w);
          end
          in_txn = 0; nacc++;
        end else begin
          wcnt++; mem_rdata = $urandom;
        end
      end else if (mem_we !== 1'b0 || mem_addr !== '0 || mem_be !== 4'b0 || mem_wdata !== 32'h0) begin
        zero_ok = 0;
      end
    end
    chk("resp_seen", got, 1);
    chk("mem_stable", stable_ok, 1);
    chk("mem_zero_when_idle", zero_ok, 1);
    chk("ready_low_when_busy", busy_ok, 1);
    @(posedge clk); #1; mem_ack = 0;
    @(negedge clk);
    chk("ready_after_resp", req_ready, 1);

    // reference model
    nb    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    a17   = int'(addr) & AMSK;
    off   = a17 & 3;
    spans = (off + nb) > 4;
    e_err = (size == 2'b11);
    if (e_err) begin
      chk("err_flag", res_err, 1);
      chk("err_rdata", res_rdata, 0);
      chk("err_no_mem", nacc, 0);
      chk("err_latency", lat, 1);
    end else begin
      e_n = spans ? 2 : 1;
      chk("err_clear", res_err, 0);
      chk("num_acc", nacc, e_n);
      chk("latency", lat, 1 + e_n * (wt + 1));
      for (int j = 0; j < 2; j++) begin e_be[j] = 0; e_wd[j] = 0; e_addr[j] = 0; end
      val = 0;
      for (int i = 0; i < nb; i++) begin
        b = (a17 + i) & AMSK;
        k = ((b >> 2) == (a17 >> 2)) ? 0 : 1;
        e_addr[k] = (b >> 2) << 2;
        e_be[k][b & 3] = 1'b1;
        e_wd[k][8*(b & 3) +: 8] = wdata[8*i +: 8];
        val[8*i +: 8] = ref_rd(b);
      end
      for (int j = 0; j < e_n; j++) begin
        chk("acc_addr", t_addr[j], e_addr[j]);
        chk("acc_be", {28'h0, t_be[j]}, {28'h0, e_be[j]});
        chk("acc_we", t_we[j], we);
        if (we) chk("acc_wdata_lanes", t_wdata[j] & lanes(e_be[j]), e_wd[j]);
      end
      if (we) begin
        chk("store_rdata", res_rdata, 0);
        for (int i = 0; i < nb; i++) refb[(a17 + i) & AMSK] = wdata[8*i +: 8];
        for (int j = 0; j < e_n; j++) begin
          for (int i = 0; i < 4; i++) wv[8*i +: 8] = ref_rd(e_addr[j] + i);
          chk("mem_after_store", dm_rd(e_addr[j] >> 2), wv);
        end
      end else begin
        if (!uns && nb < 4 && val[8*nb - 1])
          for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
        chk("load_rdata", res_rdata, val);
      end
    end
  endtask

  task automatic run_n(input string tag, input logic [1:0] size, input logic [31:0] addr,
                       input logic e_err, input int e_lat);
    int t0;
    logic saw_req;
    got = 0; saw_req = 0; lat = -1; res_err = 1'bx; res_rdata = 32'hx;
    @(posedge clk); #1;
    req_valid_n = 1; req_we = 0; req_size = size; req_unsigned = 0; req_addr = addr;
    @(negedge clk);
    t0 = cyc;
    chk({tag, "_ready"}, req_ready_n, 1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; req_valid_n = 0;
      @(negedge clk);
      if (mem_req_n) saw_req = 1;
      if (resp_valid_n) begin
        got = 1; lat = cyc - t0; res_err = resp_err_n; res_rdata = resp_rdata_n;
        break;
      end
    end
    chk({tag, "_resp_seen"}, got, 1);
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_err"}, res_err, e_err);
    if (e_err) begin
      chk({tag, "_rdata"}, res_rdata, 0);
      chk({tag, "_no_mem"}, saw_req, 0);
    end
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    rst = 1; req_valid = 0; req_valid_n = 0; req_we = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_be", {28'h0, mem_be}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);

    // aligned LW
    poke(32'h100 >> 2, 32'hDEADBEEF);
    run_req(0, 2'b10, 0, 32'h100, 0, 0);
    chk("lw_addr", t_addr[0], 32'h100);
    chk("lw_be", {28'h0, t_be[0]}, 32'hF);
    chk("lw_lat", lat, 2);
    chk("lw_rdata", res_rdata, 32'hDEADBEEF);

    // LB / LBU
    poke(32'h100 >> 2, 32'h80112233);
    run_req(0, 2'b00, 0, 32'h103, 0, 0);
    chk("lb_be", {28'h0, t_be[0]}, 32'h8);
    chk("lb_rdata", res_rdata, 32'hFFFFFF80);
    run_req(0, 2'b00, 1, 32'h103, 0, 0);
    chk("lbu_rdata", res_rdata, 32'h00000080);

    // split SH
    run_req(1, 2'b01, 0, 32'h7, 32'h0000ABCD, 0);
    chk("sh_a0", t_addr[0], 32'h4);
    chk("sh_be0", {28'h0, t_be[0]}, 32'h8);
    chk("sh_wd0", t_wdata[0], 32'hCD000000);
    chk("sh_a1", t_addr[1], 32'h8);
    chk("sh_be1", {28'h0, t_be[1]}, 32'h1);
    chk("sh_wd1", t_wdata[1], 32'h000000AB);
    chk("sh_lat", lat, 3);

    // reserved size
    run_req(0, 2'b11, 0, 32'h40, 0, 0);
    run_req(1, 2'b11, 0, 32'h41, 32'h12345678, 0);

    // wrap with wait states
    poke(32'h1FFFC >> 2, 32'h11225566);
    poke(0, 32'h77883344);
    run_req(0, 2'b10, 0, 32'h1FFFE, 0, 3);
    chk("wrap_a1", t_addr[1], 0);
    chk("wrap_lat", lat, 9);
    chk("wrap_rdata", res_rdata, 32'h33441122);

    // SPLIT_EN=0 instance
    run_n("n_lw_off2", 2'b10, 32'h202, 1, 1);
    run_n("n_size11", 2'b11, 32'h200, 1, 1);
    run_n("n_lh_off1", 2'b01, 32'h201, 0, 2);
    run_n("n_lw_off0", 2'b10, 32'h200, 0, 2);

    // reset during ACC1
    @(posedge clk); #1;
    req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'h2001;
    @(negedge clk);
    @(posedge clk); #1; req_valid = 0;
    @(negedge clk);
    chk("abort_acc0_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h01020304;
    @(posedge clk); #1; mem_ack = 0;
    @(negedge clk);
    chk("abort_acc1_req", mem_req, 1);
    chk("abort_acc1_addr", 32'(mem_addr), 32'h2004);
    chk("abort_acc1_be", {28'h0, mem_be}, 32'h1);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("abort_mem_req", mem_req, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_no_resp", resp_valid, 0);
    @(negedge clk);
    chk("abort_no_resp2", resp_valid, 0);
    run_req(1, 2'b10, 0, 32'h300, 32'hCAFEF00D, 1);

    // randomized accesses
    for (int n = 0; n < 60; n++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 7) == 0) ? 32'h1FFF0 + $urandom_range(0, 15)
                                      : 32'($urandom_range(0, 255));
      a = ($urandom & 32'hFFFE0000) | a;
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
              $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
